// File: rtl/serial_sample_rx_if.sv
// Handshake/bus bundle for serial_sample_rx: serial bit input side and
// one-deep valid/ready sample output side, plus status pulses.
interface serial_sample_rx_if #(
  parameter int SAMPLE_SIZE = 24
);
  logic                   sdata_in;
  logic                   bit_valid;
  logic                   frame_start;
  logic [SAMPLE_SIZE-1:0] out_data;
  logic [2:0]             out_chan;
  logic                   out_valid;
  logic                   out_ready;
  logic                   data_done;
  logic                   overrun;
  logic                   frame_error;
  logic [4:0]             bit_count;

  modport master (
    output sdata_in, bit_valid, frame_start, out_ready,
    input  out_data, out_chan, out_valid, data_done, overrun, frame_error, bit_count
  );

  modport slave (
    input  sdata_in, bit_valid, frame_start, out_ready,
    output out_data, out_chan, out_valid, data_done, overrun, frame_error, bit_count
  );
endinterface

// File: rtl/serial_sample_rx.sv
// Serial-to-parallel sample receiver: assembles SAMPLE_SIZE-bit words from a
// bit-strobed stream, tags them with a rotating channel index and holds them
// in a one-deep valid/ready output register.
module serial_sample_rx #(
  parameter int SAMPLE_SIZE = 24,
  parameter int CHANNELS    = 2,
  parameter int MSB_FIRST   = 1
) (
  input  logic               clk,
  input  logic               rst,
  serial_sample_rx_if.slave  bus
);

  localparam int                CNT_W     = $clog2(SAMPLE_SIZE);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(SAMPLE_SIZE - 1);
  localparam logic [2:0]        LAST_CHAN = 3'(CHANNELS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state_q,     state_d;
  logic [CNT_W-1:0]       cnt_q,       cnt_d;
  logic [2:0]             chan_q,      chan_d;
  logic [SAMPLE_SIZE-1:0] shreg_q,     shreg_d;
  logic [SAMPLE_SIZE-1:0] out_data_q,  out_data_d;
  logic [2:0]             out_chan_q,  out_chan_d;
  logic                   out_valid_q, out_valid_d;
  logic                   done_q,      done_d;
  logic                   ovr_q,       ovr_d;
  logic                   ferr_q,      ferr_d;

  logic                   drain;
  logic                   load;
  logic [SAMPLE_SIZE-1:0] shifted;

  // Bit order is fixed at elaboration; the completed word always includes
  // the bit being shifted in on the completing cycle.
  function automatic logic [SAMPLE_SIZE-1:0] shift_in(
    input logic [SAMPLE_SIZE-1:0] sr,
    input logic                   b
  );
    if (MSB_FIRST != 0) return {sr[SAMPLE_SIZE-2:0], b};
    else                return {b, sr[SAMPLE_SIZE-1:1]};
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    chan_d      = chan_q;
    shreg_d     = shreg_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    ovr_d       = 1'b0;
    ferr_d      = 1'b0;
    load        = 1'b0;
    drain       = out_valid_q & bus.out_ready;
    shifted     = shift_in(shreg_q, bus.sdata_in);

    unique case (state_q)
      IDLE: begin
        if (bus.frame_start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          chan_d  = '0;
          shreg_d = '0;
          if (bus.bit_valid) begin
            cnt_d   = CNT_W'(1);
            shreg_d = shift_in('0, bus.sdata_in);
          end
        end
      end
      SHIFT: begin
        // A frame marker restarts the word, so it can never coincide with a completion.
        if (bus.frame_start) begin
          ferr_d  = (cnt_q != '0);
          cnt_d   = '0;
          chan_d  = '0;
          shreg_d = '0;
          if (bus.bit_valid) begin
            cnt_d   = CNT_W'(1);
            shreg_d = shift_in('0, bus.sdata_in);
          end
        end else if (bus.bit_valid) begin
          shreg_d = shifted;
          if (cnt_q == LAST_BIT) begin
            cnt_d  = '0;
            chan_d = (chan_q == LAST_CHAN) ? 3'd0 : chan_q + 3'd1;
            done_d = 1'b1;
            if (!out_valid_q || drain) begin
              load       = 1'b1;
              out_data_d = shifted;
              out_chan_d = chan_q;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load)       out_valid_d = 1'b1;
    else if (drain) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      chan_q      <= '0;
      shreg_q     <= '0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      chan_q      <= chan_d;
      shreg_q     <= shreg_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
      ferr_q      <= ferr_d;
    end
  end

  assign bus.out_data    = out_data_q;
  assign bus.out_chan    = out_chan_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.data_done   = done_q;
  assign bus.overrun     = ovr_q;
  assign bus.frame_error = ferr_q;
  assign bus.bit_count   = 5'(cnt_q);

endmodule

// File: tb/tb_serial_sample_rx.sv
// Self-checking bench for serial_sample_rx: three configurations, directed
// scenarios plus a randomized run against a word-level reference model.
module tb_serial_sample_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  serial_sample_rx_if #(.SAMPLE_SIZE(24)) ifa();
  serial_sample_rx_if #(.SAMPLE_SIZE(20)) ifb();
  serial_sample_rx_if #(.SAMPLE_SIZE(5))  ifc();

  serial_sample_rx #(.SAMPLE_SIZE(24), .CHANNELS(2), .MSB_FIRST(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  serial_sample_rx #(.SAMPLE_SIZE(20), .CHANNELS(2), .MSB_FIRST(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  serial_sample_rx #(.SAMPLE_SIZE(5),  .CHANNELS(3), .MSB_FIRST(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  // Reference model for dut_a (24-bit words, 2 channels, first bit is MSB)
  localparam int AS = 24;
  localparam int AC = 2;
  bit          m_started;
  int          m_cnt, m_chan;
  logic [23:0] m_word, m_data;
  logic [2:0]  m_outchan;
  bit          m_valid;
  bit          e_dd, e_ov, e_fe;

  task automatic model_reset();
    m_started = 0; m_cnt = 0; m_chan = 0; m_word = '0;
    m_data = '0; m_outchan = '0; m_valid = 0;
    e_dd = 0; e_ov = 0; e_fe = 0;
  endtask

  // Apply one cycle of stimulus to dut_a and advance the model by one cycle.
  task automatic a_cycle(input logic sd, input logic bv, input logic fs, input logic rdy);
    int idx;
    bit drain, load;
    idx = -1; load = 0; drain = m_valid && rdy;
    e_dd = 0; e_ov = 0; e_fe = 0;
    if (fs) begin
      if (m_started && m_cnt != 0) e_fe = 1;
      m_started = 1; m_cnt = 0; m_chan = 0; m_word = '0;
      if (bv) idx = 0;
    end else if (m_started && bv) begin
      idx = m_cnt;
    end
    if (idx >= 0) begin
      m_word[AS-1-idx] = sd;
      m_cnt = idx + 1;
      if (m_cnt == AS) begin
        e_dd = 1;
        if (!m_valid || drain) begin
          m_data = m_word; m_outchan = 3'(m_chan); load = 1;
        end else begin
          e_ov = 1;
        end
        m_cnt = 0; m_chan = (m_chan + 1) % AC; m_word = '0;
      end
    end
    if (load) m_valid = 1;
    else if (drain) m_valid = 0;
    ifa.sdata_in = sd; ifa.bit_valid = bv; ifa.frame_start = fs; ifa.out_ready = rdy;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifa.sdata_in = 0; ifa.bit_valid = 0; ifa.frame_start = 0; ifa.out_ready = 0;
    ifb.sdata_in = 0; ifb.bit_valid = 0; ifb.frame_start = 0; ifb.out_ready = 0;
    ifc.sdata_in = 0; ifc.bit_valid = 0; ifc.frame_start = 0; ifc.out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({ifa.out_valid, ifa.data_done, ifa.overrun, ifa.frame_error} !== 4'b0) begin
      n_fail++; $display("FAIL reset_a_flags: got %b expected 0000", {ifa.out_valid, ifa.data_done, ifa.overrun, ifa.frame_error});
    end
    n_checks++;
    if (ifa.out_data !== 24'h0 || ifa.out_chan !== 3'd0 || ifa.bit_count !== 5'd0) begin
      n_fail++; $display("FAIL reset_a_data: got data=%h chan=%0d cnt=%0d expected 0/0/0", ifa.out_data, ifa.out_chan, ifa.bit_count);
    end
    n_checks++;
    if (ifb.out_valid !== 1'b0 || ifb.out_data !== 20'h0 || ifb.bit_count !== 5'd0) begin
      n_fail++; $display("FAIL reset_b: got valid=%b data=%h cnt=%0d expected 0/0/0", ifb.out_valid, ifb.out_data, ifb.bit_count);
    end
    n_checks++;
    if (ifc.out_valid !== 1'b0 || ifc.out_data !== 5'h0 || ifc.out_chan !== 3'd0) begin
      n_fail++; $display("FAIL reset_c: got valid=%b data=%h chan=%0d expected 0/0/0", ifc.out_valid, ifc.out_data, ifc.out_chan);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    logic [23:0] w [2];
    bit          last;
    w[0] = 24'hA5C3E1; w[1] = 24'h123456;
    for (int k = 0; k < 48; k++) begin
      a_cycle(w[k/24][23-(k%24)], 1'b1, (k == 0), 1'b1);
      last = (k == 23) || (k == 47);
      n_checks++;
      if (ifa.data_done !== last) begin
        n_fail++; $display("FAIL basic_data_done bit %0d: got %b expected %b", k, ifa.data_done, last);
      end
      n_checks++;
      if (ifa.overrun !== 1'b0) begin
        n_fail++; $display("FAIL basic_overrun bit %0d: got %b expected 0", k, ifa.overrun);
      end
      if (last) begin
        n_checks++;
        if (ifa.out_valid !== 1'b1 || ifa.out_data !== w[k/24] || ifa.out_chan !== 3'(k/24)) begin
          n_fail++; $display("FAIL basic_word %0d: got valid=%b data=%h chan=%0d expected 1/%h/%0d",
                             k/24, ifa.out_valid, ifa.out_data, ifa.out_chan, w[k/24], k/24);
        end
      end
    end
  endtask

  task automatic test_overrun();
    logic [23:0] w [4];
    int          ov_seen;
    bit          rdy;
    ov_seen = 0;
    for (int i = 0; i < 4; i++) w[i] = 24'($urandom);
    a_cycle(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < 24; b++) begin
        rdy = (i == 3) && (b == 23);
        a_cycle(w[i][23-b], 1'b1, 1'b0, rdy);
        if (ifa.overrun === 1'b1) ov_seen++;
        if (b == 23 && i == 0) begin
          n_checks++;
          if (ifa.out_valid !== 1'b1 || ifa.out_data !== w[0] || ifa.overrun !== 1'b0) begin
            n_fail++; $display("FAIL ovr_first_load: got valid=%b data=%h ovr=%b expected 1/%h/0", ifa.out_valid, ifa.out_data, ifa.overrun, w[0]);
          end
        end else if (b == 23 && i < 3) begin
          n_checks++;
          if (ifa.overrun !== 1'b1 || ifa.data_done !== 1'b1 || ifa.out_data !== w[0] || ifa.out_chan !== 3'd0) begin
            n_fail++; $display("FAIL ovr_drop %0d: got ovr=%b done=%b data=%h chan=%0d expected 1/1/%h/0", i, ifa.overrun, ifa.data_done, ifa.out_data, ifa.out_chan, w[0]);
          end
        end else if (b == 23) begin
          n_checks++;
          if (ifa.overrun !== 1'b0 || ifa.data_done !== 1'b1 || ifa.out_valid !== 1'b1 || ifa.out_data !== w[3] || ifa.out_chan !== 3'd1) begin
            n_fail++; $display("FAIL ovr_fourth_load: got ovr=%b done=%b valid=%b data=%h chan=%0d expected 0/1/1/%h/1",
                               ifa.overrun, ifa.data_done, ifa.out_valid, ifa.out_data, ifa.out_chan, w[3]);
          end
        end else if (i > 0) begin
          n_checks++;
          if (ifa.out_valid !== 1'b1 || ifa.out_data !== w[0]) begin
            n_fail++; $display("FAIL ovr_hold word %0d bit %0d: got valid=%b data=%h expected 1/%h", i, b, ifa.out_valid, ifa.out_data, w[0]);
          end
        end
      end
    end
    n_checks++;
    if (ov_seen != 2) begin
      n_fail++; $display("FAIL ovr_count: got %0d expected 2", ov_seen);
    end
    a_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (ifa.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL ovr_drain: got valid=%b expected 0", ifa.out_valid);
    end
  endtask

  task automatic test_frame_error();
    logic [23:0] w0, wp, w1;
    w0 = 24'($urandom); wp = 24'($urandom); w1 = 24'($urandom);
    for (int b = 0; b < 24; b++) begin
      a_cycle(w0[23-b], 1'b1, (b == 0), 1'b1);
      if (b == 0) begin
        n_checks++;
        if (ifa.frame_error !== 1'b0) begin
          n_fail++; $display("FAIL ferr_clean_start: got %b expected 0", ifa.frame_error);
        end
      end
    end
    for (int b = 0; b < 10; b++) a_cycle(wp[23-b], 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (ifa.bit_count !== 5'd10) begin
      n_fail++; $display("FAIL ferr_partial_count: got %0d expected 10", ifa.bit_count);
    end
    a_cycle(1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (ifa.frame_error !== 1'b1 || ifa.data_done !== 1'b0 || ifa.bit_count !== 5'd0) begin
      n_fail++; $display("FAIL ferr_pulse: got ferr=%b done=%b cnt=%0d expected 1/0/0", ifa.frame_error, ifa.data_done, ifa.bit_count);
    end
    for (int b = 0; b < 24; b++) begin
      a_cycle(w1[23-b], 1'b1, 1'b0, 1'b1);
      if (b == 0) begin
        n_checks++;
        if (ifa.frame_error !== 1'b0) begin
          n_fail++; $display("FAIL ferr_one_cycle: got %b expected 0", ifa.frame_error);
        end
      end
    end
    n_checks++;
    if (ifa.data_done !== 1'b1 || ifa.out_data !== w1 || ifa.out_chan !== 3'd0) begin
      n_fail++; $display("FAIL ferr_next_word: got done=%b data=%h chan=%0d expected 1/%h/0", ifa.data_done, ifa.out_data, ifa.out_chan, w1);
    end
  endtask

  task automatic test_random();
    logic sd, bv, fs, rdy;
    for (int c = 0; c < 3000; c++) begin
      sd  = 1'($urandom);
      bv  = ($urandom_range(0, 3) != 0);
      fs  = ($urandom_range(0, 199) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      a_cycle(sd, bv, fs, rdy);
      n_checks++;
      if ({ifa.data_done, ifa.overrun, ifa.frame_error} !== {e_dd, e_ov, e_fe}) begin
        n_fail++; $display("FAIL rand_pulses cycle %0d: got done/ovr/ferr=%b expected %b", c,
                           {ifa.data_done, ifa.overrun, ifa.frame_error}, {e_dd, e_ov, e_fe});
      end
      n_checks++;
      if (ifa.out_valid !== m_valid || ifa.bit_count !== 5'(m_cnt)) begin
        n_fail++; $display("FAIL rand_state cycle %0d: got valid=%b cnt=%0d expected %b/%0d", c, ifa.out_valid, ifa.bit_count, m_valid, m_cnt);
      end
      if (m_valid) begin
        n_checks++;
        if (ifa.out_data !== m_data || ifa.out_chan !== m_outchan) begin
          n_fail++; $display("FAIL rand_word cycle %0d: got data=%h chan=%0d expected %h/%0d", c, ifa.out_data, ifa.out_chan, m_data, m_outchan);
        end
      end
    end
    a_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    a_cycle(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_lsb_first();
    logic [19:0] w, w2;
    logic [4:0]  exp_cnt;
    w = 20'h5A3C1; w2 = 20'($urandom);
    ifb.out_ready = 1'b1;
    n_checks++;
    if (ifb.bit_count !== 5'd0) begin
      n_fail++; $display("FAIL lsb_count_start: got %0d expected 0", ifb.bit_count);
    end
    for (int i = 0; i < 20; i++) begin
      ifb.sdata_in = w[i]; ifb.bit_valid = 1'b1; ifb.frame_start = (i == 0);
      @(posedge clk); #1;
      ifb.bit_valid = 1'b0; ifb.frame_start = 1'b0;
      exp_cnt = (i == 19) ? 5'd0 : 5'(i + 1);
      n_checks++;
      if (ifb.bit_count !== exp_cnt || ifb.data_done !== (i == 19)) begin
        n_fail++; $display("FAIL lsb_step %0d: got cnt=%0d done=%b expected %0d/%b", i, ifb.bit_count, ifb.data_done, exp_cnt, (i == 19));
      end
      if (i == 19) begin
        n_checks++;
        if (ifb.out_valid !== 1'b1 || ifb.out_data !== w || ifb.out_chan !== 3'd0) begin
          n_fail++; $display("FAIL lsb_word: got valid=%b data=%h chan=%0d expected 1/%h/0", ifb.out_valid, ifb.out_data, ifb.out_chan, w);
        end
      end else begin
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (ifb.bit_count !== exp_cnt) begin
          n_fail++; $display("FAIL lsb_hold %0d: got cnt=%0d expected %0d", i, ifb.bit_count, exp_cnt);
        end
      end
    end
    for (int i = 0; i < 20; i++) begin
      ifb.sdata_in = w2[i]; ifb.bit_valid = 1'b1;
      @(posedge clk); #1;
    end
    ifb.bit_valid = 1'b0;
    n_checks++;
    if (ifb.data_done !== 1'b1 || ifb.out_data !== w2 || ifb.out_chan !== 3'd1) begin
      n_fail++; $display("FAIL lsb_second_word: got done=%b data=%h chan=%0d expected 1/%h/1", ifb.data_done, ifb.out_data, ifb.out_chan, w2);
    end
  endtask

  task automatic test_channels();
    logic [4:0] w [7];
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) w[i] = 5'($urandom);
    for (int i = 0; i < 7; i++) begin
      for (int b = 0; b < 5; b++) begin
        ifc.sdata_in = w[i][4-b]; ifc.bit_valid = 1'b1; ifc.frame_start = (i == 0 && b == 0);
        @(posedge clk); #1;
      end
      n_checks++;
      if (ifc.data_done !== 1'b1 || ifc.out_data !== w[i] || ifc.out_chan !== 3'(i % 3)) begin
        n_fail++; $display("FAIL chan_word %0d: got done=%b data=%h chan=%0d expected 1/%h/%0d", i, ifc.data_done, ifc.out_data, ifc.out_chan, w[i], i % 3);
      end
    end
    ifc.bit_valid = 1'b0; ifc.frame_start = 1'b0;
  endtask

  task automatic test_reset_midword();
    logic [23:0] w0, w1;
    w0 = 24'($urandom); w1 = 24'($urandom);
    for (int b = 0; b < 24; b++) a_cycle(w0[23-b], 1'b1, (b == 0), 1'b0);
    for (int b = 0; b < 7; b++)  a_cycle(w1[23-b], 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (ifa.out_valid !== 1'b1 || ifa.out_data !== w0 || ifa.bit_count !== 5'd7) begin
      n_fail++; $display("FAIL rstmid_pre: got valid=%b data=%h cnt=%0d expected 1/%h/7", ifa.out_valid, ifa.out_data, ifa.bit_count, w0);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({ifa.out_valid, ifa.data_done, ifa.overrun, ifa.frame_error} !== 4'b0 ||
        ifa.out_data !== 24'h0 || ifa.out_chan !== 3'd0 || ifa.bit_count !== 5'd0) begin
      n_fail++; $display("FAIL rstmid_async: got valid=%b data=%h chan=%0d cnt=%0d expected all 0",
                         ifa.out_valid, ifa.out_data, ifa.out_chan, ifa.bit_count);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int c = 0; c < 30; c++) begin
      a_cycle(1'($urandom), 1'b1, 1'b0, 1'b1);
      n_checks++;
      if (ifa.bit_count !== 5'd0 || ifa.data_done !== 1'b0 || ifa.out_valid !== 1'b0) begin
        n_fail++; $display("FAIL rstmid_idle %0d: got cnt=%0d done=%b valid=%b expected 0/0/0", c, ifa.bit_count, ifa.data_done, ifa.out_valid);
      end
    end
    for (int b = 0; b < 24; b++) a_cycle(w1[23-b], 1'b1, (b == 0), 1'b1);
    n_checks++;
    if (ifa.data_done !== 1'b1 || ifa.out_data !== w1 || ifa.out_chan !== 3'd0) begin
      n_fail++; $display("FAIL rstmid_restart: got done=%b data=%h chan=%0d expected 1/%h/0", ifa.data_done, ifa.out_data, ifa.out_chan, w1);
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_basic();
    test_overrun();
    test_frame_error();
    test_random();
    test_lsb_first();
    test_channels();
    test_reset_midword();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
